// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath stages: default width, flag layout
// and the result word carried between stages.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic              sub;
  } alu_word_t;

  function automatic logic [3:0] make_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered in_ready.
// The main entry drives the output; the skid entry absorbs one word of backpressure.
module alu_skid_buf #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  skid_state_t  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         emit;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      // NOTE: in_ready defaults high every cycle; only the branches that end in
      // FULL pull it low, and the later non-blocking assignment wins.
      in_ready <= 1'b1;
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_q <= skid_q;
            state  <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage after the adder/subtractor: derives N/Z/C/V, buffers
// result+flags through a skid buffer and tracks overflow statistics on accept.
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic              in_sub,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              out_sub,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_sticky,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  import alu_pkg::*;

  localparam int PAY_W = DATA_W + 5;

  logic [3:0]       in_flags;
  logic [PAY_W-1:0] in_word;
  logic [PAY_W-1:0] out_word;
  logic             accept;

  assign in_flags = make_flags(in_sum[DATA_W-1], in_sum == '0, in_carry, in_ovf);
  assign in_word  = {in_sum, in_flags, in_sub};
  assign accept   = in_valid & in_ready;

  alu_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_result = out_word[PAY_W-1:5];
  assign out_flags  = out_word[4:1];
  assign out_sub    = out_word[0];

  // An overflowing accept beats a simultaneous clear: the clear is applied
  // first, so the count restarts at 1 rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && in_ovf) begin
      ovf_sticky <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= CNT_W'(1);
      end else if (ovf_count != '1) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_alu_result_stage;

  import alu_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_sum;
  logic              in_carry, in_ovf, in_sub, in_valid, in_ready;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;
  logic              out_sub, out_valid, out_ready, clr_sticky, ovf_sticky;
  logic [CNT_W-1:0]  ovf_count;

  alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_sum(in_sum), .in_carry(in_carry), .in_ovf(in_ovf), .in_sub(in_sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_result(out_result), .out_flags(out_flags), .out_sub(out_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words held by the stage in acceptance order, plus statistics.
  alu_word_t q[$];
  logic      rdy_m  = 1'b0;
  logic      stk_m  = 1'b0;
  int        cnt_m  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic alu_word_t ref_word(input logic [DATA_W-1:0] s, input logic c,
                                         input logic v, input logic sb);
    alu_word_t w;
    w.result = s;
    w.flags  = {s[DATA_W-1], (s == 0), c, v};
    w.sub    = sb;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    rdy_m = 1'b0;
    stk_m = 1'b0;
    cnt_m = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, (q.size() != 0));
    check("in_ready", in_ready, rdy_m);
    check("ovf_sticky", ovf_sticky, stk_m);
    check("ovf_count", ovf_count, cnt_m);
    if (q.size() != 0) begin
      check("out_result", out_result, q[0].result);
      check("out_flags", out_flags, q[0].flags);
      check("out_sub", out_sub, q[0].sub);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    logic acc, emt;
    @(negedge clk);
    check_outputs();
    acc = in_valid && rdy_m;
    emt = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(ref_word(in_sum, in_carry, in_ovf, in_sub));
      if (acc && in_ovf) begin
        stk_m = 1'b1;
        cnt_m = clr_sticky ? 1 : ((cnt_m < CNT_MAX) ? cnt_m + 1 : CNT_MAX);
      end else if (clr_sticky) begin
        stk_m = 1'b0;
        cnt_m = 0;
      end
      rdy_m = (q.size() < 2);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] s, input logic c,
                       input logic o, input logic sb, input logic ordy, input logic clr);
    in_valid   = v;
    in_sum     = s;
    in_carry   = c;
    in_ovf     = o;
    in_sub     = sb;
    out_ready  = ordy;
    clr_sticky = clr;
    tick();
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] stream_vals [3];
    stream_vals = '{16'h0001, 16'h0000, 16'h8000};

    // Reset held 3 cycles with in_valid asserted.
    rst = 1'b1;
    in_valid = 1'b1; in_sum = 16'hBEEF; in_carry = 1'b1; in_ovf = 1'b1; in_sub = 1'b1;
    out_ready = 1'b1; clr_sticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_flags", out_flags, 4'b0000);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rdy_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    rdy_m = 1'b1;
    check("rdy_after_edge", in_ready, 1'b1);

    // Streaming with out_ready high: one word per cycle, latency 1.
    for (int i = 0; i < 3; i++) drive(1'b1, stream_vals[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Backpressure: second word lands in the skid entry; a third is refused.
    drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_hold", out_result, 16'h1234);
    idle(1'b1, 3);

    // Overflow: 0x7FFF + 0x0001 repeated until the counter saturates.
    drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ovf_flags", out_flags, 4'b1001);
    check("ovf_first_cnt", ovf_count, 1);
    for (int i = 1; i < 300; i++) drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);
    check("ovf_saturated", ovf_count, CNT_MAX);

    // Clear collision starting from count 5.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_collide_cnt", ovf_count, 5);
    drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("collide_cnt", ovf_count, 1);
    check("collide_stk", ovf_sticky, 1'b1);
    idle(1'b1, 2);

    // Mid-operation reset while FULL: outputs drop immediately, old words gone.
    drive(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_rdy", in_ready, 1'b0);
    model_reset();
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    idle(1'b1, 3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end
    idle(1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
